conv_weight_store: RTL and testbench
====================================

// Module: conv_weight_store
// PURPOSE
// - Responder for the conv controller's weight-read port; holds one output group's weight words in BRAM.
// - Loads words from the host/DMA stream, packing LOAD_WIDTH beats into WT_DATA_WIDTH words.
// - Returns a word exactly WT_LATENCY cycles after each wt_rd_en, aligned with the delayed conv_valid_in.
// - Sits between the DMA weight stream and conv_3x3; wt_data_ready gates the controller's start.
// PARAMETERS
// - WT_ADDR_WIDTH  12   word address width; depth = 2**WT_ADDR_WIDTH
// - WT_DATA_WIDTH  576  word width (8 ch x 9 taps x 8 b)
// - LOAD_WIDTH     64   stream beat width; WT_DATA_WIDTH % LOAD_WIDTH == 0
// - WT_LATENCY     3    rd_en -> rd_data latency, fixed; must be >= 3
// PORTS
// - clk            in   1                clock
// - rst            in   1                synchronous, active-high reset
// - cfg_load_base  in   WT_ADDR_WIDTH    first word address of the load
// - cfg_load_words in   WT_ADDR_WIDTH+1  words to load; 0 = empty load
// - load_go        in   1                start-load pulse
// - s_wt_tdata     in   LOAD_WIDTH       weight beat, LSB-first within a word
// - s_wt_tvalid    in   1                beat valid
// - s_wt_tlast     in   1                final beat of the load
// - s_wt_tready    out  1                beat accepted when tvalid & tready
// - wt_rd_en       in   1                read request from conv controller
// - wt_rd_addr     in   WT_ADDR_WIDTH    read word address
// - wt_rd_data     out  WT_DATA_WIDTH    read word
// - wt_rd_valid    out  1                wt_rd_data valid, wt_rd_en delayed by WT_LATENCY
// - wt_data_ready  out  1                load complete; reads return loaded data
// - load_err       out  1                sticky: tlast mismatch or read during load
// BEHAVIOUR
// - Reset: FSM IDLE; s_wt_tready, wt_rd_valid, wt_data_ready, load_err = 0; wt_rd_data = 0;
//   beat/word counters and read pipe cleared. BRAM contents are not cleared.
// - FSM IDLE: load_go -> LOAD (words>0) or DONE (words==0). Latch base/words; clear load_err.
// - LOAD: s_wt_tready = 1. Each accepted beat goes into the shift register at slice beat_cnt.
//   When beat_cnt wraps (BEATS-1 -> 0), write the word at base+word_cnt, mod 2**WT_ADDR_WIDTH,
//   and increment word_cnt. After the last word is written -> DONE.
// - tlast: must coincide with the final beat. Early tlast or missing tlast: set load_err;
//   early tlast -> DONE with a partial load. Beats after the final word are not accepted
//   (tready = 0).
// - DONE: wt_data_ready = 1 until the next load_go, which re-enters LOAD the next cycle
//   with ready dropped. load_go in LOAD is ignored.
// - Read pipe: stage1 registers addr/en; stage2 is the BRAM registered read; stage3 is the
//   output register. Extra stages are added as delay regs when WT_LATENCY > 3.
//   wt_rd_valid = wt_rd_en delayed WT_LATENCY; wt_rd_data holds its value when valid = 0.
// - Back-to-back rd_en every cycle: full throughput, one word per cycle, no bubbles.
// - Read in LOAD: data undefined; set load_err; wt_rd_valid still asserts on schedule.
// - Same-cycle write and read of one address: read returns the old word.
// - Reset mid-load: abort to IDLE; partially written words remain; wt_data_ready = 0.
// STRUCTURE
// - Shared package conv_pkg: wt_load_state_t {IDLE,LOAD,DONE}; WT_LATENCY default is shared
//   with conv_controller so that PIPE_DEPTH agrees.
// - One sub-module: wt_bram_sdp (simple dual port, 1 write / 1 registered read, no reset on
//   the array).
// - Top level: load FSM, beat packer, latency delay line.
// TESTING
// - Load 4 words (36 beats, tlast on beat 36), base 0x010 -> ready rises the cycle after
//   beat 36; read 0x010..0x013 returns the packed words.
// - rd_en every cycle on addrs 0x010..0x013 -> rd_valid high for 4 cycles starting exactly
//   3 cycles after the first rd_en; data in order.
// - base 0xFFE, words 4 -> writes go to 0xFFE, 0xFFF, 0x000, 0x001; readback matches.
// - tlast on beat 20 of a 36-beat load -> load_err=1, ready=1, words 0-1 written, word 2
//   not written.
// - Assert rst at beat 10 -> tready=0, ready=0, rd_valid=0 next cycle; a new load completes
//   normally.
// - words=0 with load_go -> ready=1 the next cycle; no tready; no writes.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared conv-engine types and defaults.
// The weight store and conv controller share WT_LATENCY_DEF so their pipe depths agree.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } wt_load_state_t;

    localparam int WT_LATENCY_DEF = 3;

endpackage

// File: rtl/wt_bram_sdp.sv
// Simple dual-port block RAM: one write port, one registered read port.
// Read-first: a same-cycle write and read of one address returns the old word.
module wt_bram_sdp #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 576
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/conv_weight_store.sv
// Weight store for conv_3x3: packs the DMA beat stream into BRAM words
// and answers controller reads with a fixed-latency pipe.
module conv_weight_store
    import conv_pkg::*;
#(
    parameter int WT_ADDR_WIDTH = 12,
    parameter int WT_DATA_WIDTH = 576,
    parameter int LOAD_WIDTH    = 64,
    parameter int WT_LATENCY    = WT_LATENCY_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WT_ADDR_WIDTH-1:0] cfg_load_base,
    input  logic [WT_ADDR_WIDTH:0]   cfg_load_words,
    input  logic                     load_go,
    input  logic [LOAD_WIDTH-1:0]    s_wt_tdata,
    input  logic                     s_wt_tvalid,
    input  logic                     s_wt_tlast,
    output logic                     s_wt_tready,
    input  logic                     wt_rd_en,
    input  logic [WT_ADDR_WIDTH-1:0] wt_rd_addr,
    output logic [WT_DATA_WIDTH-1:0] wt_rd_data,
    output logic                     wt_rd_valid,
    output logic                     wt_data_ready,
    output logic                     load_err
);

    localparam int BEATS = WT_DATA_WIDTH / LOAD_WIDTH;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int EXTRA = WT_LATENCY - 3;

    wt_load_state_t state, state_nxt;

    logic [WT_ADDR_WIDTH-1:0] base_q;
    logic [WT_ADDR_WIDTH:0]   words_q;
    logic [WT_ADDR_WIDTH:0]   word_cnt;
    logic [BW-1:0]            beat_cnt;
    logic [WT_DATA_WIDTH-1:0] shreg;

    logic                     beat_acc;
    logic                     last_beat;
    logic                     final_beat;
    logic                     we;
    logic [WT_ADDR_WIDTH-1:0] waddr;
    logic [WT_DATA_WIDTH-1:0] wdata;

    assign s_wt_tready   = (state == LOAD);
    assign wt_data_ready = (state == DONE);

    assign beat_acc   = s_wt_tready & s_wt_tvalid;
    assign last_beat  = (beat_cnt == BW'(BEATS - 1));
    assign final_beat = last_beat &&
                        (word_cnt == words_q - (WT_ADDR_WIDTH + 1)'(1));

    assign we    = beat_acc & last_beat;
    assign waddr = base_q + word_cnt[WT_ADDR_WIDTH-1:0];

    // The completing beat bypasses the shift register straight into the word.
    always_comb begin
        wdata = shreg;
        wdata[(BEATS-1)*LOAD_WIDTH +: LOAD_WIDTH] = s_wt_tdata;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: begin
                if (load_go)
                    state_nxt = (cfg_load_words == '0) ? DONE : LOAD;
            end
            LOAD: begin
                if (beat_acc && (final_beat || s_wt_tlast))
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            base_q   <= '0;
            words_q  <= '0;
            word_cnt <= '0;
            beat_cnt <= '0;
            load_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state != LOAD && load_go) begin
                base_q   <= cfg_load_base;
                words_q  <= cfg_load_words;
                word_cnt <= '0;
                beat_cnt <= '0;
                load_err <= 1'b0;
            end else if (state == LOAD) begin
                if (beat_acc) begin
                    beat_cnt <= last_beat ? '0 : beat_cnt + BW'(1);
                    if (last_beat)
                        word_cnt <= word_cnt + (WT_ADDR_WIDTH + 1)'(1);
                    // tlast must land exactly on the final beat
                    if (s_wt_tlast != final_beat)
                        load_err <= 1'b1;
                end
                if (wt_rd_en)
                    load_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (beat_acc)
            shreg[int'(beat_cnt)*LOAD_WIDTH +: LOAD_WIDTH] <= s_wt_tdata;
    end

    logic                     en1;
    logic [WT_ADDR_WIDTH-1:0] addr1;
    logic                     en2;
    logic [WT_DATA_WIDTH-1:0] rdata;
    logic                     tail_en;
    logic [WT_DATA_WIDTH-1:0] tail_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            en1   <= 1'b0;
            addr1 <= '0;
            en2   <= 1'b0;
        end else begin
            en1   <= wt_rd_en;
            addr1 <= wt_rd_addr;
            en2   <= en1;
        end
    end

    wt_bram_sdp #(
        .ADDR_WIDTH(WT_ADDR_WIDTH),
        .DATA_WIDTH(WT_DATA_WIDTH)
    ) u_bram (
        .clk  (clk),
        .we   (we),
        .waddr(waddr),
        .wdata(wdata),
        .re   (en1),
        .raddr(addr1),
        .rdata(rdata)
    );

    generate
        if (EXTRA > 0) begin : g_delay
            logic [EXTRA-1:0]         den;
            logic [WT_DATA_WIDTH-1:0] dd [EXTRA];

            always_ff @(posedge clk) begin
                if (rst) begin
                    den <= '0;
                end else begin
                    den[0] <= en2;
                    for (int i = 1; i < EXTRA; i++)
                        den[i] <= den[i-1];
                end
            end

            always_ff @(posedge clk) begin
                dd[0] <= rdata;
                for (int i = 1; i < EXTRA; i++)
                    dd[i] <= dd[i-1];
            end

            assign tail_en = den[EXTRA-1];
            assign tail_d  = dd[EXTRA-1];
        end else begin : g_nodelay
            assign tail_en = en2;
            assign tail_d  = rdata;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            wt_rd_valid <= 1'b0;
            wt_rd_data  <= '0;
        end else begin
            wt_rd_valid <= tail_en;
            if (tail_en)
                wt_rd_data <= tail_d;
        end
    end

endmodule

// File: tb/tb_conv_weight_store.sv
// Scoreboard bench for conv_weight_store: loads drive a memory model,
// reads push expected words, a negedge monitor checks data and latency.
module tb_conv_weight_store;

    localparam int AW    = 12;
    localparam int DW    = 576;
    localparam int LW    = 64;
    localparam int BEATS = DW / LW;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] cfg_load_base;
    logic [AW:0]   cfg_load_words;
    logic          load_go;
    logic [LW-1:0] s_wt_tdata;
    logic          s_wt_tvalid;
    logic          s_wt_tlast;
    logic          s_wt_tready;
    logic          wt_rd_en;
    logic [AW-1:0] wt_rd_addr;
    logic [DW-1:0] wt_rd_data;
    logic          wt_rd_valid;
    logic          wt_data_ready;
    logic          load_err;

    conv_weight_store dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_load_base (cfg_load_base),
        .cfg_load_words(cfg_load_words),
        .load_go       (load_go),
        .s_wt_tdata    (s_wt_tdata),
        .s_wt_tvalid   (s_wt_tvalid),
        .s_wt_tlast    (s_wt_tlast),
        .s_wt_tready   (s_wt_tready),
        .wt_rd_en      (wt_rd_en),
        .wt_rd_addr    (wt_rd_addr),
        .wt_rd_data    (wt_rd_data),
        .wt_rd_valid   (wt_rd_valid),
        .wt_data_ready (wt_data_ready),
        .load_err      (load_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc++;

    typedef struct {
        logic [DW-1:0] d;
        int            c;
        bit            dc;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] mem_model [int];

    function automatic logic [LW-1:0] beat(int tag, int w, int b);
        return {8'(tag), 24'h5A5A00 ^ 24'(w * 16), 16'(b),
                16'hC3C3 ^ 16'(tag * 37)};
    endfunction

    function automatic logic [DW-1:0] word(int tag, int w);
        logic [DW-1:0] r;
        for (int b = 0; b < BEATS; b++)
            r[b*LW +: LW] = beat(tag, w, b);
        return r;
    endfunction

    task automatic chk1(string nm, logic a, logic e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", nm, a, e);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && wt_rd_valid) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL rd_unexpected: valid at cyc %0d, none pending", cyc);
            end else begin
                e = q.pop_front();
                if (cyc != e.c + 3 || (!e.dc && wt_rd_data !== e.d)) begin
                    n_bad++;
                    $display("FAIL rd_data: cyc %0d want cyc %0d got %h want %h",
                             cyc, e.c + 3, wt_rd_data, e.d);
                end
            end
        end else if (!rst && q.size() > 0 && cyc >= q[0].c + 3) begin
            e = q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL rd_missing: no valid at cyc %0d want cyc %0d",
                     cyc, e.c + 3);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_burst(int a0, int n, int gap);
        int a;
        for (int i = 0; i < n; i++) begin
            a = (a0 + i) & 12'hFFF;
            wt_rd_en   = 1'b1;
            wt_rd_addr = AW'(a);
            q.push_back('{mem_model[a], cyc, 1'b0});
            tick();
            wt_rd_en = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++)
            tick();
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d reads outstanding want 0", q.size());
            q.delete();
        end
    endtask

    // tlast_at: 0 = on final beat, >0 = early at that beat, -1 = never
    task automatic load(int base, int words, int tag, int tlast_at,
                        int rst_at, int rd_at);
        int total, acc;
        total          = words * BEATS;
        acc            = 0;
        cfg_load_base  = AW'(base);
        cfg_load_words = (AW + 1)'(words);
        load_go        = 1'b1;
        tick();
        load_go = 1'b0;
        chk1("ready_drop", wt_data_ready, 1'b0);
        for (int n = 1; n <= total; n++) begin
            if (tlast_at > 0 && n > tlast_at)
                break;
            if (rst_at == n)
                rst = 1'b1;
            s_wt_tvalid = 1'b1;
            s_wt_tdata  = beat(tag, (n - 1) / BEATS, (n - 1) % BEATS);
            s_wt_tlast  = (tlast_at == 0) ? (n == total) : (n == tlast_at);
            if (rd_at == n) begin
                wt_rd_en   = 1'b1;
                wt_rd_addr = AW'(base);
                q.push_back('{'0, cyc, 1'b1});
            end
            tick();
            wt_rd_en = 1'b0;
            if (rd_at == n)
                chk1("rd_in_load_err", load_err, 1'b1);
            if (rst_at == n)
                break;
            acc = n;
        end
        s_wt_tvalid = 1'b0;
        s_wt_tlast  = 1'b0;
        for (int w = 0; w < acc / BEATS; w++)
            mem_model[(base + w) & 12'hFFF] = word(tag, w);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        cfg_load_base  = '0;
        cfg_load_words = '0;
        load_go        = 1'b0;
        s_wt_tdata     = '0;
        s_wt_tvalid    = 1'b0;
        s_wt_tlast     = 1'b0;
        wt_rd_en       = 1'b0;
        wt_rd_addr     = '0;
        repeat (3) tick();
        chk1("rst_ready", wt_data_ready, 1'b0);
        chk1("rst_tready", s_wt_tready, 1'b0);
        chk1("rst_err", load_err, 1'b0);
        chk1("rst_valid", wt_rd_valid, 1'b0);
        chk1("rst_data_zero", wt_rd_data == '0, 1'b1);
        rst = 1'b0;
        tick();

        load(12'h010, 4, 1, 0, 0, 0);
        chk1("t1_ready", wt_data_ready, 1'b1);
        chk1("t1_tready", s_wt_tready, 1'b0);
        chk1("t1_err", load_err, 1'b0);
        rd_burst(12'h010, 4, 0);
        drain();

        load(12'hFFE, 4, 2, 0, 0, 0);
        chk1("t2_ready", wt_data_ready, 1'b1);
        chk1("t2_err", load_err, 1'b0);
        rd_burst(12'hFFE, 4, 2);
        drain();

        load(12'h020, 4, 3, 0, 0, 0);
        load(12'h020, 4, 4, 20, 0, 0);
        chk1("t3_err", load_err, 1'b1);
        chk1("t3_ready", wt_data_ready, 1'b1);
        chk1("t3_tready", s_wt_tready, 1'b0);
        rd_burst(12'h020, 4, 1);
        drain();

        load(12'h030, 4, 5, 0, 10, 5);
        chk1("t4_tready", s_wt_tready, 1'b0);
        chk1("t4_ready", wt_data_ready, 1'b0);
        chk1("t4_valid", wt_rd_valid, 1'b0);
        chk1("t4_err", load_err, 1'b0);
        rst = 1'b0;
        tick();
        load(12'h030, 4, 6, 0, 0, 0);
        chk1("t4b_ready", wt_data_ready, 1'b1);
        chk1("t4b_err", load_err, 1'b0);
        rd_burst(12'h030, 4, 0);
        drain();

        load(12'h040, 1, 7, -1, 0, 0);
        chk1("t5_err", load_err, 1'b1);
        chk1("t5_ready", wt_data_ready, 1'b1);
        rd_burst(12'h040, 1, 0);
        drain();

        cfg_load_base  = 12'h010;
        cfg_load_words = '0;
        load_go        = 1'b1;
        tick();
        load_go = 1'b0;
        chk1("t6_ready", wt_data_ready, 1'b1);
        chk1("t6_err", load_err, 1'b0);
        s_wt_tvalid = 1'b1;
        s_wt_tlast  = 1'b1;
        s_wt_tdata  = 64'hDEAD_BEEF_0BAD_F00D;
        repeat (3) begin
            chk1("t6_tready", s_wt_tready, 1'b0);
            tick();
        end
        s_wt_tvalid = 1'b0;
        s_wt_tlast  = 1'b0;
        rd_burst(12'h010, 4, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
